// File: rtl/serial_add_ctrl_pkg.sv
// Purpose: shared constants and the state type for the bit-serial add/subtract controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // 2'd3 is unused; the FSM steers it back to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// Purpose: single 1-bit full adder, the only arithmetic cell of the serial engine.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b, cin -> sum, co.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic co
);

  assign sum = a ^ b ^ cin;
  assign co  = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Purpose: bit-serial A+B+cin / A-B engine, LSB first, one fa_bit reused WIDTH times.
// Latency: accept edge E0, done high in the cycle after edge E0+WIDTH; one op per WIDTH+2 cycles.
// Backpressure: start is sampled only in IDLE; requests while busy are dropped, not queued.
// Ports: clk, rst_n, start, sub, cin_in, op_a, op_b -> busy, done, result, cout, ovf.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin_in,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic [WIDTH-1:0] r_result;
  logic             r_c;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;
  logic             w_sum;
  logic             w_co;
  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic [WIDTH-1:0] w_s_nxt;

  fa_bit u_fa (
    .a   (r_a_sh[0]),
    .b   (r_b_sh[0]),
    .cin (r_c),
    .sum (w_sum),
    .co  (w_co)
  );

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_run    = (r_state == S_RUN);
  assign w_last   = w_run && (r_cnt == LAST_BIT);
  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign w_s_nxt  = {w_sum, r_s_sh[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == LAST_BIT) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        busy        = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_s_sh   <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is A + ~B + 1: invert B once here and force the carry-in.
      r_a_sh <= op_a;
      r_b_sh <= sub ? ~op_b : op_b;
      r_c    <= sub ? 1'b1 : cin_in;
      r_cnt  <= '0;
    end else if (w_run) begin
      r_a_sh <= r_a_sh >> 1;
      r_b_sh <= r_b_sh >> 1;
      r_s_sh <= w_s_nxt;
      r_c    <= w_co;
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) begin
        // On the MSB step r_c is the carry into the MSB, so overflow needs no extra register.
        r_result <= w_s_nxt;
        r_cout   <= w_co;
        r_ovf    <= r_c ^ w_co;
      end
    end
  end

  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start8, sub8, cin8;
  logic [7:0] a8, b8, res8;
  logic       busy8, done8, cout8, ovf8;
  logic       start4, sub4, cin4;
  logic [3:0] a4, b4, res4;
  logic       busy4, done4, cout4, ovf4;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sb;
    logic [7:0] r;
    logic       co;
    logic       ov;
  } vec_t;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .cin_in(cin8),
    .op_a(a8), .op_b(b8), .busy(busy8), .done(done8), .result(res8),
    .cout(cout8), .ovf(ovf8)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .cin_in(cin4),
    .op_a(a4), .op_b(b4), .busy(busy4), .done(done4), .result(res4),
    .cout(cout4), .ovf(ovf4)
  );

  // Drives one op into dut8 and observes 12 cycles after the accept edge.
  // Cycle k is the cycle following edge E0+k-1. Inputs are scrambled after accept.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sb, output logic [7:0] r, output logic co,
                         output logic ov, output int done_at, output int done_cnt,
                         output int busy_cnt, output logic held);
    logic [7:0] prev;
    prev = res8; held = 1'b1; r = '0; co = 1'b0; ov = 1'b0;
    done_at = 0; done_cnt = 0; busy_cnt = 0;
    a8 = a; b8 = b; cin8 = cin; sub8 = sb; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~cin; sub8 = ~sb;
    for (int k = 1; k <= 12; k++) begin
      if (busy8) busy_cnt++;
      if (done8) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
        r = res8; co = cout8; ov = ovf8;
      end else if (done_cnt == 0 && res8 !== prev) begin
        held = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy8); end
    n_vec++; if (done8 !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done8); end
    n_vec++; if (res8 !== 8'h00) begin n_err++; $display("FAIL reset_result: got %h expected 00", res8); end
    n_vec++; if ({cout8, ovf8} !== 2'b00) begin n_err++; $display("FAIL reset_cout_ovf: got %b expected 00", {cout8, ovf8}); end
    n_vec++; if ({busy4, done4, res4} !== 6'b0) begin n_err++; $display("FAIL reset_w4: got %b expected 000000", {busy4, done4, res4}); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL idle_no_start: busy got %b expected 0", busy8); end
  endtask

  task automatic test_add_basic;
    logic [7:0] r; logic co, ov, held; int dat, dcnt, bcnt;
    run_op8(8'h35, 8'h4A, 1'b0, 1'b0, r, co, ov, dat, dcnt, bcnt, held);
    n_vec++; if (bcnt != 9) begin n_err++; $display("FAIL add_busy_cycles: got %0d expected 9", bcnt); end
    n_vec++; if (dcnt != 1) begin n_err++; $display("FAIL add_done_pulses: got %0d expected 1", dcnt); end
    n_vec++; if (dat != 9) begin n_err++; $display("FAIL add_done_cycle: got %0d expected 9", dat); end
    n_vec++; if (held !== 1'b1) begin n_err++; $display("FAIL add_result_held: got %b expected 1", held); end
    n_vec++; if ({r, co, ov} !== {8'h7F, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL add_35_4a: got r=%h co=%b ov=%b expected r=7f co=0 ov=0", r, co, ov);
    end
  endtask

  task automatic test_add_carry_ovf;
    vec_t v[3];
    logic [7:0] r; logic co, ov, held; int dat, dcnt, bcnt;
    v[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    v[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    v[2] = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      run_op8(v[i].a, v[i].b, v[i].cin, v[i].sb, r, co, ov, dat, dcnt, bcnt, held);
      n_vec++; if ({dcnt, r, co, ov} !== {32'd1, v[i].r, v[i].co, v[i].ov}) begin
        n_err++; $display("FAIL add_vec[%0d]: got done=%0d r=%h co=%b ov=%b expected done=1 r=%h co=%b ov=%b",
                          i, dcnt, r, co, ov, v[i].r, v[i].co, v[i].ov);
      end
    end
  endtask

  task automatic test_subtract;
    vec_t v[3];
    logic [7:0] r; logic co, ov, held; int dat, dcnt, bcnt;
    v[0] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    v[1] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    v[2] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};  // cin_in must be ignored
    for (int i = 0; i < 3; i++) begin
      run_op8(v[i].a, v[i].b, v[i].cin, v[i].sb, r, co, ov, dat, dcnt, bcnt, held);
      n_vec++; if ({dcnt, r, co, ov} !== {32'd1, v[i].r, v[i].co, v[i].ov}) begin
        n_err++; $display("FAIL sub_vec[%0d]: got done=%0d r=%h co=%b ov=%b expected done=1 r=%h co=%b ov=%b",
                          i, dcnt, r, co, ov, v[i].r, v[i].co, v[i].ov);
      end
    end
  endtask

  task automatic test_back_to_back;
    int dn;
    int dk[3];
    logic [7:0] dr[3];
    logic dc[3], dv[3];
    logic [7:0] er[3];
    logic ec[3], ev[3];
    er[0] = 8'h7F; ec[0] = 1'b0; ev[0] = 1'b0;
    er[1] = 8'hF0; ec[1] = 1'b0; ev[1] = 1'b0;
    er[2] = 8'h2D; ec[2] = 1'b1; ev[2] = 1'b0;
    dn = 0;
    for (int i = 0; i < 3; i++) begin dk[i] = 0; dr[i] = '0; dc[i] = 1'b0; dv[i] = 1'b0; end
    a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 30; k++) begin
      if (done8) begin
        if (dn < 3) begin dk[dn] = k; dr[dn] = res8; dc[dn] = cout8; dv[dn] = ovf8; end
        dn++;
      end
      start8 = (k < 30);
      if (k == 10) begin
        a8 = 8'h10; b8 = 8'h20; sub8 = 1'b1; cin8 = 1'b0;
      end else if (k == 20) begin
        a8 = 8'hC8; b8 = 8'h64; sub8 = 1'b0; cin8 = 1'b1;
      end else begin
        a8 = 8'hA5 ^ 8'(k); b8 = 8'h3C + 8'(k); sub8 = k[0]; cin8 = k[1];
      end
      @(posedge clk); #1;
    end
    start8 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    n_vec++; if (dn != 3) begin n_err++; $display("FAIL b2b_done_count: got %0d expected 3", dn); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if ({dk[i], dr[i], dc[i], dv[i]} !== {9 + 10 * i, er[i], ec[i], ev[i]}) begin
        n_err++; $display("FAIL b2b_op[%0d]: got cyc=%0d r=%h co=%b ov=%b expected cyc=%0d r=%h co=%b ov=%b",
                          i, dk[i], dr[i], dc[i], dv[i], 9 + 10 * i, er[i], ec[i], ev[i]);
      end
    end
  endtask

  task automatic test_reset_mid_op;
    logic [7:0] r; logic co, ov, held; int dat, dcnt, bcnt, late_done, late_busy;
    a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy8); end
    n_vec++; if (done8 !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b expected 0", done8); end
    n_vec++; if (res8 !== 8'h00) begin n_err++; $display("FAIL midrst_result: got %h expected 00", res8); end
    n_vec++; if ({cout8, ovf8} !== 2'b00) begin n_err++; $display("FAIL midrst_cout_ovf: got %b expected 00", {cout8, ovf8}); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    late_done = 0; late_busy = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done8) late_done++;
      if (busy8) late_busy++;
    end
    n_vec++; if ({late_done, late_busy} != 64'd0) begin
      n_err++; $display("FAIL midrst_no_done: got done=%0d busy=%0d expected 0 0", late_done, late_busy);
    end
    run_op8(8'hC8, 8'h64, 1'b1, 1'b0, r, co, ov, dat, dcnt, bcnt, held);
    n_vec++; if ({dcnt, r, co, ov} !== {32'd1, 8'h2D, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL midrst_next_op: got done=%0d r=%h co=%b ov=%b expected done=1 r=2d co=1 ov=0", dcnt, r, co, ov);
    end
  endtask

  task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                         input logic sb, output logic [3:0] r, output logic co,
                         output logic ov, output int cyc);
    r = '0; co = 1'b0; ov = 1'b0; cyc = 0;
    a4 = a; b4 = b; cin4 = cin; sub4 = sb; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (done4) begin
        r = res4; co = cout4; ov = ovf4; cyc = k;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive_w4;
    logic [3:0] r, er; logic co, ov, eco, eov; int cyc, ua, ub, sa, sbv, u, s;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          for (int m = 0; m < 2; m++) begin
            ua = a; ub = b;
            sa = (a >= 8) ? a - 16 : a;
            sbv = (b >= 8) ? b - 16 : b;
            if (m == 1) begin
              u = ua + (15 - ub) + 1;
              s = sa - sbv;
            end else begin
              u = ua + ub + c;
              s = sa + sbv + c;
            end
            er = u[3:0]; eco = (u > 15); eov = (s > 7) || (s < -8);
            run_op4(4'(a), 4'(b), c[0], m[0], r, co, ov, cyc);
            n_vec++; if ({cyc, r, co, ov} !== {32'd5, er, eco, eov}) begin
              n_err++; $display("FAIL w4 a=%0d b=%0d cin=%0d sub=%0d: got cyc=%0d r=%h co=%b ov=%b expected cyc=5 r=%h co=%b ov=%b",
                                a, b, c, m, cyc, r, co, ov, er, eco, eov);
            end
          end
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_add_basic;
    test_add_carry_ovf;
    test_subtract;
    test_back_to_back;
    test_reset_mid_op;
    test_exhaustive_w4;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract controller that time-multiplexes a single 1-bit full-adder cell across a WIDTH-bit operation, LSB first.
- Accepts operands with a start pulse, sequences one bit per clock, and returns the result, carry-out and signed overflow with a one-cycle done pulse.
- Serves as the low-area arithmetic engine for control paths where latency is cheap and gates are not.

Parameters:
- WIDTH, 8, operand/result width in bits (2 to 32).
- CW, $clog2(WIDTH), bit-counter width, derived; not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = A+B+cin_in, 1 = A-B (B inverted, carry-in forced to 1, cin_in ignored).
- cin_in  input  1  carry-in for add mode.
- op_a  input  WIDTH  operand A, latched on accept.
- op_b  input  WIDTH  operand B, latched on accept.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result, cout and ovf are valid from this cycle on.
- result  output  WIDTH  sum/difference, registered.
- cout  output  1  carry out of the MSB (subtract: 1 = no borrow).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, done, result, cout, ovf = 0. Internal shift registers, carry register and counter = 0.
- States are IDLE, RUN and DONE. busy = (state != IDLE). done = (state == DONE), Moore.
- IDLE:
  - start=1 at an edge: accept.
  - Latch A_sh=op_a and B_sh = sub ? ~op_b : op_b.
  - Set c = sub ? 1 : cin_in, cnt=0, state=RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - Full-adder cell inputs are A_sh[0], B_sh[0] and c.
  - A_sh and B_sh shift right.
  - Sum bit enters the MSB of the internal shadow register S_sh, which shifts right.
  - c <= carry out; cnt++.
  - When cnt==WIDTH-1: also capture c_msb_in = c, the carry into the MSB.
  - After the WIDTH-th RUN edge:
    - result <= final S_sh, including the current bit.
    - cout <= final carry.
    - ovf <= c_msb_in ^ final carry.
    - state=DONE.
- DONE: lasts one cycle; next edge goes to IDLE unconditionally.
- Timing:
  - Accept at edge E0.
  - done is high in the cycle after edge E0+WIDTH, and low again after E0+WIDTH+1.
  - The earliest next accept is at edge E0+WIDTH+2.
  - Throughput is one operation per WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored; no queuing.
- Operand, sub and cin_in changes after accept have no effect.
- result, cout and ovf hold their last values until the next completion. They are never partially updated mid-operation.
- Reset asserted mid-RUN:
  - Immediate return to IDLE; outputs go to 0 and done does not fire.
  - After rst_n deasserts, the first edge with start=1 is a normal accept.
- Width rule: all arithmetic is modulo 2^WIDTH. cout carries the extra bit; no sign extension.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - A default-WIDTH constant.
- One sub-module, fa_bit: a purely combinational 1-bit full adder with ports a, b, cin, sum and co, instantiated once.
- Controller FSM, counter and shift registers live in serial_add_ctrl.

Test Plan (WIDTH=8 unless noted):
- Add, no overflow: op_a=0x35, op_b=0x4A, cin_in=0, sub=0, start one cycle.
  - Required: busy=1 for 9 cycles; done pulses once, 9 edges after accept.
  - result=0x7F, cout=0, ovf=0.
- Add with carry and signed overflow:
  - 0xFF+0x01 -> result=0x00, cout=1, ovf=0.
  - 0x7F+0x01 -> result=0x80, cout=0, ovf=1.
  - 0x00+0x00 with cin_in=1 -> result=0x01.
- Subtract: sub=1.
  - 0x10-0x20 -> result=0xF0, cout=0, ovf=0.
  - 0x80-0x01 -> result=0x7F, cout=1, ovf=1.
- Busy rejection: start held high continuously.
  - Operations complete back-to-back every 10 cycles.
  - Operand changes mid-op do not alter the in-flight result.
- Reset mid-op: accept 0x35+0x4A, pull rst_n low at RUN bit 3.
  - Required: busy, result, cout, ovf and done go to 0 immediately.
  - No done pulse follows; the next accepted op computes correctly.
- Exhaustive check with WIDTH=4: all a, b, cin_in and sub combinations against a reference model for result, cout and ovf.
